// File: rtl/mem_bist_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mem_bist_initiator
// Purpose  : Memory BIST requester for a single-port synchronous memory
//            (rw=0 write, rw=1 read, read data valid one cycle after issue).
//            On a start pulse it writes pattern(a) = a ^ SEED to every
//            address, reads every address back through a 1-stage compare
//            pipeline and reports pass/fail, mismatch count and the first
//            failing address.
// Ports    : clk, reset (sync, active-low), start
//            mem_rw, mem_addr, mem_wdata  -> memory
//            mem_rdata                    <- memory
//            busy, done, pass, err_count, first_err_addr -> control
// Options  : MEM_BIST_INV_PASS_EN adds a second pass (WRITE_INV/READ_INV)
//            using the inverted pattern; errors from both passes accumulate.
// Revision : 1.0  initial release
// ============================================================================
module mem_bist_initiator #(
   parameter int            AW   = 8,
   parameter int            DW   = 8,
   parameter logic [DW-1:0] SEED = 8'hA5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          mem_rw,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW:0]   err_count,
   output logic [AW-1:0] first_err_addr
);

   localparam logic [AW-1:0] c_last_addr = '1;
   localparam logic [AW:0]   c_err_max   = '1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WRITE     = 3'd1,
      S_READ      = 3'd2,
      S_DRAIN     = 3'd3,
`ifdef MEM_BIST_INV_PASS_EN
      S_WRITE_INV = 3'd5,
      S_READ_INV  = 3'd6,
`endif
      S_DONE      = 3'd4
   } state_t;

   // Zero-extend (or truncate) the address to DW bits, then mix in the seed.
   function automatic logic [DW-1:0] f_pattern(input logic [AW-1:0] a);
      return DW'(a) ^ SEED;
   endfunction

   state_t        r_state,  w_state;
   logic          r_rw,     w_rw;
   logic [AW-1:0] r_addr,   w_addr;
   logic [DW-1:0] r_wdata,  w_wdata;
   logic          r_busy,   w_busy;
   logic          r_done,   w_done;
   logic          r_pass,   w_pass;
   logic [AW:0]   r_err,    w_err;
   logic [AW-1:0] r_first,  w_first;
   // Compare pipeline: expected data and address of the read in flight.
   logic          r_pv,     w_pv;
   logic [DW-1:0] r_pexp,   w_pexp;
   logic [AW-1:0] r_paddr,  w_paddr;

   always_comb begin
      w_state = r_state;
      w_rw    = r_rw;
      w_addr  = r_addr;
      w_wdata = r_wdata;
      w_busy  = r_busy;
      w_done  = 1'b0;
      w_pass  = r_pass;
      w_err   = r_err;
      w_first = r_first;
      w_pv    = 1'b0;
      w_pexp  = r_pexp;
      w_paddr = r_paddr;

      // Compare stage runs independently of the state so the last read of a
      // pass can be checked while the next state is already active.
      if (r_pv && (mem_rdata != r_pexp)) begin
         if (r_err != c_err_max) begin
            w_err = r_err + 1'b1;
         end
         if (r_err == '0) begin
            w_first = r_paddr;
         end
      end

      case (r_state)
         S_IDLE: begin
            w_rw   = 1'b1;
            w_addr = '0;
            if (start) begin
               w_state = S_WRITE;
               w_rw    = 1'b0;
               w_wdata = f_pattern('0);
               w_busy  = 1'b1;
               w_err   = '0;
               w_first = '0;
               w_pass  = 1'b0;
            end
         end
         S_WRITE: begin
            w_addr = r_addr + 1'b1;
            if (r_addr == c_last_addr) begin
               w_state = S_READ;
               w_addr  = '0;
               w_rw    = 1'b1;
            end else begin
               w_wdata = f_pattern(r_addr + 1'b1);
            end
         end
         S_READ: begin
            w_pv    = 1'b1;
            w_pexp  = f_pattern(r_addr);
            w_paddr = r_addr;
            w_addr  = r_addr + 1'b1;
            if (r_addr == c_last_addr) begin
               w_addr = '0;
`ifdef MEM_BIST_INV_PASS_EN
               w_state = S_WRITE_INV;
               w_rw    = 1'b0;
               w_wdata = ~f_pattern('0);
`else
               w_state = S_DRAIN;
`endif
            end
         end
`ifdef MEM_BIST_INV_PASS_EN
         S_WRITE_INV: begin
            w_addr = r_addr + 1'b1;
            if (r_addr == c_last_addr) begin
               w_state = S_READ_INV;
               w_addr  = '0;
               w_rw    = 1'b1;
            end else begin
               w_wdata = ~f_pattern(r_addr + 1'b1);
            end
         end
         S_READ_INV: begin
            w_pv    = 1'b1;
            w_pexp  = ~f_pattern(r_addr);
            w_paddr = r_addr;
            w_addr  = r_addr + 1'b1;
            if (r_addr == c_last_addr) begin
               w_state = S_DRAIN;
               w_addr  = '0;
            end
         end
`endif
         S_DRAIN: begin
            // Final compare lands on this edge; pass uses the updated count.
            w_state = S_DONE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_pass  = (w_err == '0);
         end
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_rw    <= 1'b1;
         r_addr  <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_err   <= '0;
         r_first <= '0;
         r_pv    <= 1'b0;
         r_pexp  <= '0;
         r_paddr <= '0;
      end else begin
         r_state <= w_state;
         r_rw    <= w_rw;
         r_addr  <= w_addr;
         r_wdata <= w_wdata;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_pass  <= w_pass;
         r_err   <= w_err;
         r_first <= w_first;
         r_pv    <= w_pv;
         r_pexp  <= w_pexp;
         r_paddr <= w_paddr;
      end
   end

   assign mem_rw         = r_rw;
   assign mem_addr       = r_addr;
   assign mem_wdata      = r_wdata;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_count      = r_err;
   assign first_err_addr = r_first;

endmodule
`default_nettype wire
